// File: rtl/dac_pkg.sv
// Shared definitions for the DAC transmit path: run-state encoding and
// the offset-binary midscale code.
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_RUN     = 2'd2,
        ST_STARVED = 2'd3
    } dac_state_e;

    // Midscale code for a w-bit offset-binary DAC (MSB set, rest clear).
    function automatic logic [31:0] dac_midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO with occupancy output; callers gate push on !full and pop on !empty.
module dac_sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dac_sample_interpolator.sv
// Buffers low-rate signed samples and linearly interpolates them by 2**LOG2_RATE
// into one offset-binary DAC code per clock, flagging starved boundaries.
module dac_sample_interpolator
    import dac_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int LOG2_RATE  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [DATA_WIDTH-1:0]         s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [DATA_WIDTH-1:0]         dac_data_o,
    output logic                          dac_en_o,
    output logic                          underflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int DW   = DATA_WIDTH;
    localparam int ACCW = DATA_WIDTH + 1 + LOG2_RATE;
    localparam logic [DW-1:0] MID = DW'(dac_midscale(DW));

    dac_state_e              state;
    logic [LOG2_RATE-1:0]    phase;
    logic signed [DW-1:0]    cur;
    logic signed [DW:0]      delta;
    logic signed [ACCW-1:0]  acc;

    logic [DW-1:0]           rdata;
    logic signed [DW-1:0]    sample;
    logic                    fifo_full, fifo_empty;
    logic                    active, boundary, pop, push;

    assign active    = (state != ST_IDLE);
    assign boundary  = active && (phase == '0);
    assign pop       = en_i && boundary && !fifo_empty;
    assign s_ready_o = !fifo_full;
    assign push      = s_valid_i && s_ready_o;
    assign sample    = rdata;

    dac_sample_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wdata  (s_data_i),
        .rdata  (rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level_o)
    );

    // The ramp always starts from cur at the boundary, so the previous sample
    // needs no register of its own; delta is sized so acc lands exactly on the target.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            phase       <= '0;
            cur         <= '0;
            delta       <= '0;
            acc         <= '0;
            dac_data_o  <= MID;
            dac_en_o    <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            // acc[DW+L-1:L] is floor(acc / R) truncated; XOR with MID flips the sign bit.
            dac_data_o  <= acc[DW+LOG2_RATE-1:LOG2_RATE] ^ MID;
            dac_en_o    <= active;
            underflow_o <= 1'b0;
            if (!en_i) begin
                state <= ST_IDLE;
                phase <= '0;
                cur   <= '0;
                delta <= '0;
                acc   <= '0;
            end else if (state == ST_IDLE) begin
                state <= ST_PRIME;
            end else begin
                phase <= phase + 1'b1;
                if (boundary) begin
                    acc <= ACCW'(cur) <<< LOG2_RATE;
                    if (!fifo_empty) begin
                        cur   <= sample;
                        delta <= {sample[DW-1], sample} - {cur[DW-1], cur};
                        state <= ST_RUN;
                    end else begin
                        delta <= '0;
                        if (state != ST_PRIME) begin
                            state       <= ST_STARVED;
                            underflow_o <= 1'b1;
                        end
                    end
                end else begin
                    acc <= acc + ACCW'(delta);
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_interpolator.sv
// Directed bench for dac_sample_interpolator at defaults (10-bit, R=8, depth 4).
module tb_dac_sample_interpolator;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic [9:0] s_data_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [9:0] dac_data_o;
    logic       dac_en_o;
    logic       underflow_o;
    logic [2:0] fifo_level_o;

    int n_chk = 0;
    int n_bad = 0;
    int nuf;

    always #5 clk_i = ~clk_i;

    dac_sample_interpolator dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .dac_data_o   (dac_data_o),
        .dac_en_o     (dac_en_o),
        .underflow_o  (underflow_o),
        .fifo_level_o (fifo_level_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int v);
        s_data_i  = 10'(v);
        s_valid_i = 1'b1;
        step(1);
        s_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
        step(2);
        chk("rst_data", dac_data_o, 'h200);
        chk("rst_en", dac_en_o, 0);
        chk("rst_ready", s_ready_o, 1);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_uf", underflow_o, 0);
        rst_ni = 1'b1;
        step(1);

        // Ramp 0 -> 80, then hold with periodic underflow
        push(0); push(80);
        chk("lvl2", fifo_level_o, 2);
        en_i = 1'b1;
        step(1);
        chk("en_idle", dac_en_o, 0);
        chk("data_idle", dac_data_o, 'h200);
        step(1);
        chk("en_prime", dac_en_o, 1);
        chk("lvl_pop0", fifo_level_o, 1);
        step(8);
        chk("lvl_pop80", fifo_level_o, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("ramp80", dac_data_o, 'h200 + 10 * i);
            chk("uf_ramp80", underflow_o, 32'(i == 7));
        end
        step(1);
        chk("hold80", dac_data_o, 'h250);
        chk("uf_clr", underflow_o, 0);
        step(7);
        chk("uf_again", underflow_o, 1);
        chk("hold80b", dac_data_o, 'h250);

        // Full-scale ramp -512 -> 511
        push(-512); push(511);
        step(6);
        chk("lvl_fs1", fifo_level_o, 1);
        step(8);
        chk("lvl_fs0", fifo_level_o, 0);
        for (int j = 0; j <= 8; j++) begin
            step(1);
            chk("ramp_fs", dac_data_o, (1023 * j) >> 3);
            if (j == 7) chk("uf_fs", underflow_o, 1);
        end

        // Two samples, long stall, then resume from the held value
        push(100); push(200);
        nuf = 0;
        repeat (37) begin step(1); nuf += int'(underflow_o); end
        push(300);
        nuf += int'(underflow_o);
        repeat (6) begin step(1); nuf += int'(underflow_o); end
        chk("uf_count", nuf, 3);
        chk("hold200", dac_data_o, 'h2C8);
        step(1); chk("resume0", dac_data_o, 'h2C8);
        step(1); chk("resume1", dac_data_o, 'h2C8);
        step(1); chk("resume2", dac_data_o, 'h2D4);

        // Fill while disabled; fifth push must wait for space
        en_i = 1'b0;
        push(10); push(20); push(30); push(40);
        chk("lvl_full", fifo_level_o, 4);
        chk("ready_full", s_ready_o, 0);
        s_data_i = 10'd50; s_valid_i = 1'b1;
        step(2);
        chk("lvl_wait", fifo_level_o, 4);
        chk("ready_wait", s_ready_o, 0);
        chk("en_off", dac_en_o, 0);
        chk("data_off", dac_data_o, 'h200);
        en_i = 1'b1;
        step(2);
        chk("full_pop", fifo_level_o, 3);
        step(1);
        chk("late_push", fifo_level_o, 4);
        s_valid_i = 1'b0;
        step(7);
        chk("lvl_drop1", fifo_level_o, 3);
        step(8);
        chk("lvl_drop2", fifo_level_o, 2);

        // Asynchronous reset mid-ramp
        step(3);
        chk("mid_ramp", dac_data_o, 'h216);
        rst_ni = 1'b0;
        #1;
        chk("arst_data", dac_data_o, 'h200);
        chk("arst_en", dac_en_o, 0);
        chk("arst_level", fifo_level_o, 0);
        chk("arst_ready", s_ready_o, 1);
        chk("arst_uf", underflow_o, 0);
        en_i = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(1);
        en_i = 1'b1;
        nuf = 0;
        repeat (11) begin step(1); nuf += int'(underflow_o); end
        chk("prime_no_uf", nuf, 0);
        chk("prime_en", dac_en_o, 1);
        chk("prime_data", dac_data_o, 'h200);
        push(7);
        step(6);
        chk("reprime_pop", fifo_level_o, 0);
        step(8);
        chk("reprime_uf", underflow_o, 1);
        step(1);
        chk("reprime_val", dac_data_o, 'h207);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
